// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the streaming matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_BIAS,
        S_DONE
    } state_t;

    localparam int DEF_DW      = 8;
    localparam int DEF_K_MAX   = 16;
    localparam int DEF_MAX_DIM = 4;

    localparam int K_W    = $clog2(DEF_K_MAX + 1);
    localparam int CNT_W  = $clog2(2 * DEF_MAX_DIM);
    localparam int PROD_W = 2 * DEF_DW;

    function automatic int k_w(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int cnt_w(input int dim);
        return $clog2(2 * dim);
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Operand beat stream: one column of A and one row of B per accepted beat.
interface matmul_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N*DW-1:0] a_col_i;
    logic [N*DW-1:0] b_row_i;
    logic            in_valid_i;
    logic            in_ready_o;

    modport master (output a_col_i, output b_row_i, output in_valid_i, input in_ready_o);
    modport slave  (input a_col_i, input b_row_i, input in_valid_i, output in_ready_o);
endinterface

// File: rtl/matmul_pe.sv
// One systolic processing element: forwards a/b/valid and accumulates a*b on tagged beats.
module matmul_pe #(
    parameter int DW = 8,
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          sat_en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          valid,
    output logic [DW-1:0] a_pass,
    output logic [DW-1:0] b_pass,
    output logic          valid_pass,
    output logic [BW-1:0] acc,
    output logic          ovf
);
    localparam int PW = 2 * DW;

    logic [PW-1:0] prod;
    logic [BW:0]   sum;

    assign prod = PW'(a) * PW'(b);
    assign sum  = {1'b0, acc} + (BW+1)'(prod);

    // A carry out of the accumulator is sticky; with saturation the value pins at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_pass     <= '0;
            b_pass     <= '0;
            valid_pass <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
        end else begin
            a_pass     <= a;
            b_pass     <= b;
            valid_pass <= valid;
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (valid) begin
                if (sum[BW]) begin
                    ovf <= 1'b1;
                    acc <= sat_en ? '1 : sum[BW-1:0];
                end else begin
                    acc <= sum[BW-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/matmul_stream_engine.sv
// Output-stationary N x N systolic matrix multiplier fed one A column / B row per beat.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int DW      = 8,
    parameter int BW      = 32,
    parameter int MAX_DIM = 4,
    parameter int K_MAX   = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic [$clog2(K_MAX+1)-1:0]       k_len_i,
    input  logic                             bias_en_i,
    input  logic                             sat_en_i,
    matmul_if.slave                          stream,
    input  logic [MAX_DIM*MAX_DIM*BW-1:0]    c_mat_i,
    output logic [MAX_DIM*MAX_DIM*BW-1:0]    res_mat_o,
    output logic [MAX_DIM*MAX_DIM-1:0]       of_mat_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             res_valid_o
);
    localparam int N  = MAX_DIM;
    localparam int KW = k_w(K_MAX);
    localparam int CW = cnt_w(MAX_DIM);

    state_t        state, next_state;
    logic [KW-1:0] k_eff, beats_left;
    logic [CW-1:0] drain_cnt;
    logic          bias_lat, sat_lat, accept, fire;

    logic [DW-1:0] a_h [N][N+1];
    logic [DW-1:0] b_v [N+1][N];
    logic          v_h [N][N+1];
    logic [BW-1:0] acc_arr [N*N];
    logic          ovf_arr [N*N];
    logic [BW:0]   bsum    [N*N];

    assign k_eff  = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
    assign accept = (state == S_IDLE) && start_i;
    assign fire   = stream.in_valid_i && stream.in_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state        = state;
        stream.in_ready_o = 1'b0;
        busy_o            = (state != S_IDLE);
        done_o            = (state == S_DONE);
        case (state)
            S_IDLE:  if (start_i) next_state = (k_eff == '0) ? S_BIAS : S_FEED;
            S_FEED: begin
                stream.in_ready_o = 1'b1;
                if (fire && beats_left == KW'(1)) next_state = S_DRAIN;
            end
            S_DRAIN: if (drain_cnt == '0) next_state = S_BIAS;
            S_BIAS:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Drain length covers the skew to the far corner PE after the last beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beats_left  <= '0;
            drain_cnt   <= '0;
            bias_lat    <= 1'b0;
            sat_lat     <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                beats_left  <= k_eff;
                bias_lat    <= bias_en_i;
                sat_lat     <= sat_en_i;
                res_valid_o <= 1'b0;
            end
            if (state == S_FEED && fire) begin
                beats_left <= beats_left - KW'(1);
                if (beats_left == KW'(1)) drain_cnt <= CW'(2*N-2);
            end
            if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - CW'(1);
            if (state == S_BIAS) res_valid_o <= 1'b1;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row_skew
        logic [DW-1:0] a_dl [0:r];
        logic          v_dl [0:r];
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int d = 0; d <= r; d++) begin
                    a_dl[d] <= '0;
                    v_dl[d] <= 1'b0;
                end
            end else begin
                a_dl[0] <= stream.a_col_i[r*DW +: DW];
                v_dl[0] <= fire;
                for (int d = 1; d <= r; d++) begin
                    a_dl[d] <= a_dl[d-1];
                    v_dl[d] <= v_dl[d-1];
                end
            end
        end
        assign a_h[r][0] = a_dl[r];
        assign v_h[r][0] = v_dl[r];
    end

    for (genvar c = 0; c < N; c++) begin : g_col_skew
        logic [DW-1:0] b_dl [0:c];
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int d = 0; d <= c; d++) b_dl[d] <= '0;
            end else begin
                b_dl[0] <= stream.b_row_i[c*DW +: DW];
                for (int d = 1; d <= c; d++) b_dl[d] <= b_dl[d-1];
            end
        end
        assign b_v[0][c] = b_dl[c];
    end

    for (genvar r = 0; r < N; r++) begin : g_pe_row
        for (genvar c = 0; c < N; c++) begin : g_pe_col
            matmul_pe #(.DW(DW), .BW(BW)) u_pe (
                .clk        (clk_i),
                .reset      (reset_i),
                .clr        (accept),
                .sat_en     (sat_lat),
                .a          (a_h[r][c]),
                .b          (b_v[r][c]),
                .valid      (v_h[r][c]),
                .a_pass     (a_h[r][c+1]),
                .b_pass     (b_v[r+1][c]),
                .valid_pass (v_h[r][c+1]),
                .acc        (acc_arr[r*N+c]),
                .ovf        (ovf_arr[r*N+c])
            );
            assign bsum[r*N+c] = {1'b0, acc_arr[r*N+c]} +
                                 (bias_lat ? {1'b0, c_mat_i[(r*N+c)*BW +: BW]} : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            res_mat_o <= '0;
            of_mat_o  <= '0;
        end else if (state == S_BIAS) begin
            for (int i = 0; i < N*N; i++) begin
                res_mat_o[i*BW +: BW] <= (sat_lat && bsum[i][BW]) ? {BW{1'b1}} : bsum[i][BW-1:0];
                of_mat_o[i]           <= ovf_arr[i] | bsum[i][BW];
            end
        end
    end
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed bench: a 32-bit and a 16-bit accumulator instance share one operand stream.
module tb_matmul_stream_engine;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [4:0]      k_len = '0;
    logic            bias_en = 1'b0;
    logic            sat_en = 1'b0;
    logic [N*8-1:0]  a_col = '0;
    logic [N*8-1:0]  b_row = '0;
    logic            in_valid = 1'b0;
    logic [N*N*32-1:0] c32 = '0, res32;
    logic [N*N*16-1:0] c16 = '0, res16;
    logic [N*N-1:0]  of32, of16;
    logic            busy32, done32, rv32, busy16, done16, rv16;

    logic [N*8-1:0]  a_beats [0:19];
    logic [N*8-1:0]  b_beats [0:19];
    int checks = 0;
    int errors = 0;

    matmul_if #(.N(N), .DW(8)) s32 ();
    matmul_if #(.N(N), .DW(8)) s16 ();

    assign s32.a_col_i = a_col;  assign s32.b_row_i = b_row;  assign s32.in_valid_i = in_valid;
    assign s16.a_col_i = a_col;  assign s16.b_row_i = b_row;  assign s16.in_valid_i = in_valid;

    matmul_stream_engine #(.DW(8), .BW(32), .MAX_DIM(N), .K_MAX(16)) dut32 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .k_len_i(k_len),
        .bias_en_i(bias_en), .sat_en_i(sat_en), .stream(s32), .c_mat_i(c32),
        .res_mat_o(res32), .of_mat_o(of32), .busy_o(busy32), .done_o(done32),
        .res_valid_o(rv32)
    );

    matmul_stream_engine #(.DW(8), .BW(16), .MAX_DIM(N), .K_MAX(16)) dut16 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .k_len_i(k_len),
        .bias_en_i(bias_en), .sat_en_i(sat_en), .stream(s16), .c_mat_i(c16),
        .res_mat_o(res16), .of_mat_o(of16), .busy_o(busy16), .done_o(done16),
        .res_valid_o(rv16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkMatrix(input string tag, input bit use16,
                               input logic [31:0] expv [16], input logic [15:0] exp_of);
        for (int i = 0; i < 16; i++) begin
            if (use16) checkOutput($sformatf("%s_res16[%0d]", tag, i), {48'b0, res16[i*16 +: 16]}, {32'b0, expv[i]});
            else       checkOutput($sformatf("%s_res32[%0d]", tag, i), {32'b0, res32[i*32 +: 32]}, {32'b0, expv[i]});
        end
        checkOutput({tag, "_of"}, use16 ? of16 : of32, exp_of);
    endtask

    // Starts a product in IDLE, streams beats (optionally with a bubble before each),
    // and returns the cycle (relative to the start cycle) in which done_o rose; 0 on timeout.
    task automatic applyStimulus(input int k, input bit bias, input bit sat, input bit bubbles, output int lat);
        int  b = 0;
        bit  phase = 1'b0;
        bit  took;
        lat = 0;
        start = 1'b1; k_len = 5'(k); bias_en = bias; sat_en = sat;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (b < k && !(bubbles && !phase)) begin
                in_valid = 1'b1; a_col = a_beats[b]; b_row = b_beats[b];
            end else begin
                in_valid = 1'b0;
            end
            phase = ~phase;
            took = in_valid && s32.in_ready_o;
            @(posedge clk); #1;
            if (took) b++;
            if (done32) begin
                lat = n + 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (lat == 0) checkOutput("done_timeout", 64'd0, 64'd1);
        checkOutput("rv_in_done", rv32, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic loadIdentity();
        for (int kk = 0; kk < 4; kk++)
            for (int x = 0; x < 4; x++) begin
                a_beats[kk][x*8 +: 8] = (x == kk) ? 8'd1 : 8'd0;
                b_beats[kk][x*8 +: 8] = 8'((x + 1) * (kk + 1));
            end
    endtask

    initial begin
        int lat;
        logic [31:0] e [16];

        repeat (3) @(posedge clk); #1;
        checkOutput("rst_res_any", |res32, 1'b0);
        checkOutput("rst_of", of32, 16'h0);
        checkOutput("rst_busy", busy32, 1'b0);
        checkOutput("rst_done", done32, 1'b0);
        checkOutput("rst_rv", rv32, 1'b0);
        checkOutput("rst_ready", s32.in_ready_o, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Identity A times B returns B.
        loadIdentity();
        for (int i = 0; i < 16; i++) e[i] = 32'(((i % 4) + 1) * ((i / 4) + 1));
        applyStimulus(4, 0, 0, 0, lat);
        checkOutput("lat_ident", lat, 13);
        checkMatrix("ident", 0, e, 16'h0);

        // Same product with a bubble before every beat.
        applyStimulus(4, 0, 0, 1, lat);
        checkOutput("lat_bubble", lat, 17);
        checkMatrix("bubble", 0, e, 16'h0);

        // Outer product plus a constant bias.
        for (int x = 0; x < 4; x++) begin
            a_beats[0][x*8 +: 8] = 8'(x + 1);
            b_beats[0][x*8 +: 8] = 8'(x + 5);
        end
        for (int i = 0; i < 16; i++) begin
            c32[i*32 +: 32] = 32'd10;
            c16[i*16 +: 16] = 16'd10;
            e[i] = 32'(((i / 4) + 1) * ((i % 4) + 5) + 10);
        end
        applyStimulus(1, 1, 0, 0, lat);
        checkOutput("lat_k1", lat, 10);
        checkMatrix("bias", 0, e, 16'h0);
        c32 = '0; c16 = '0;

        // 16-bit accumulators overflow on 2 x 255*255; 32-bit ones do not.
        for (int kk = 0; kk < 2; kk++) begin
            a_beats[kk] = {N{8'hFF}};
            b_beats[kk] = {N{8'hFF}};
        end
        applyStimulus(2, 0, 1, 0, lat);
        checkOutput("lat_k2", lat, 11);
        for (int i = 0; i < 16; i++) e[i] = 32'h0000FFFF;
        checkMatrix("sat", 1, e, 16'hFFFF);
        for (int i = 0; i < 16; i++) e[i] = 32'd130050;
        checkMatrix("nosat32", 0, e, 16'h0);
        applyStimulus(2, 0, 0, 0, lat);
        for (int i = 0; i < 16; i++) e[i] = 32'h0000FC02;
        checkMatrix("wrap", 1, e, 16'hFFFF);

        // Requested K above the maximum is clamped to 16 beats of ones.
        for (int kk = 0; kk < 20; kk++) begin
            a_beats[kk] = {N{8'h01}};
            b_beats[kk] = {N{8'h01}};
        end
        applyStimulus(20, 0, 0, 0, lat);
        checkOutput("lat_clamp", lat, 25);
        for (int i = 0; i < 16; i++) e[i] = 32'd16;
        checkMatrix("clamp", 0, e, 16'h0);

        // Reset in the middle of DRAIN, then a clean rerun.
        loadIdentity();
        start = 1'b1; k_len = 5'd4; bias_en = 1'b0; sat_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            in_valid = 1'b1; a_col = a_beats[kk]; b_row = b_beats[kk];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("drain_busy", busy32, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_rst_res_any", |res32, 1'b0);
        checkOutput("mid_rst_of", of32, 16'h0);
        checkOutput("mid_rst_busy", busy32, 1'b0);
        checkOutput("mid_rst_done", done32, 1'b0);
        checkOutput("mid_rst_rv", rv32, 1'b0);
        checkOutput("mid_rst_ready", s32.in_ready_o, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) e[i] = 32'(((i % 4) + 1) * ((i / 4) + 1));
        applyStimulus(4, 0, 0, 0, lat);
        checkOutput("lat_rerun", lat, 13);
        checkMatrix("rerun", 0, e, 16'h0);

        // K=0 with bias 7 while start stays high through the whole busy period.
        for (int i = 0; i < 16; i++) begin
            c32[i*32 +: 32] = 32'd7;
            e[i] = 32'd7;
        end
        start = 1'b1; k_len = 5'd0; bias_en = 1'b1; sat_en = 1'b0;
        @(posedge clk); #1;
        checkOutput("k0_busy_t1", busy32, 1'b1);
        checkOutput("k0_done_t1", done32, 1'b0);
        checkOutput("k0_ready_t1", s32.in_ready_o, 1'b0);
        @(posedge clk); #1;
        checkOutput("k0_done_t2", done32, 1'b1);
        checkMatrix("k0", 0, e, 16'h0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("k0_idle_busy", busy32, 1'b0);
        checkOutput("k0_idle_done", done32, 1'b0);
        checkOutput("k0_rv_held", rv32, 1'b1);
        @(posedge clk); #1;
        checkOutput("k0_no_restart", busy32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matmul_stream_engine.md
MATMUL_STREAM_ENGINE -- requirements
Module: matmul_stream_engine

Interface
REQ-001 SHALL have parameter DW, default 8, operand element width in bits (unsigned).
REQ-002 SHALL have parameter BW, default 32, accumulator/result element width in bits.
REQ-003 SHALL have parameter MAX_DIM, default 4, array is MAX_DIM x MAX_DIM PEs (N below).
REQ-004 SHALL have parameter K_MAX, default 16, maximum runtime inner dimension.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk_i  in  1  rising-edge clock; reset_i  in  1  synchronous active-high reset.
REQ-006 SHALL have start_i  in  1  request a new product; sampled only in IDLE.
REQ-007 SHALL have k_len_i  in  $clog2(K_MAX+1)  inner dimension K, latched on start.
REQ-008 SHALL have bias_en_i  in  1  add c_mat_i to the result, latched on start.
REQ-009 SHALL have sat_en_i  in  1  saturate instead of wrap, latched on start.
REQ-010 SHALL have a_col_i  in  N*DW  column kk of A; row r at bits [(r+1)*DW-1:r*DW].
REQ-011 SHALL have b_row_i  in  N*DW  row kk of B; column c at bits [(c+1)*DW-1:c*DW].
REQ-012 SHALL have in_valid_i  in  1 and in_ready_o  out  1  operand beat handshake.
REQ-013 SHALL have c_mat_i  in  N*N*BW  bias matrix, element i=r*N+c at [(i+1)*BW-1:i*BW], sampled in BIAS.
REQ-014 SHALL have res_mat_o  out  N*N*BW  result, same packing; of_mat_o  out  N*N  per-element overflow flags.
REQ-015 SHALL have busy_o  out  1, done_o  out  1, res_valid_o  out  1.

Function
REQ-016 SHALL implement FSM IDLE -> FEED -> DRAIN -> BIAS -> DONE -> IDLE.
REQ-017 IDLE: start_i=1 latches K, bias_en, sat_en, clears all accumulators and overflow flags, clears res_valid_o; next state FEED (or BIAS if K=0).
REQ-018 FEED: in_ready_o=1; a beat transfers when in_valid_i&in_ready_o; after K transfers go to DRAIN; in_ready_o=0 in every other state.
REQ-019 in_valid_i low in FEED SHALL insert a bubble; a valid tag travels with the skewed data and PEs accumulate only on tagged beats.
REQ-020 Skew: A row r delayed r cycles, B column c delayed c cycles; PE(r,c) accumulates beat kk r+c+1 cycles after its transfer.
REQ-021 DRAIN SHALL last exactly 2*N-1 cycles (down-counter), then BIAS.
REQ-022 PE product DW x DW -> 2*DW, accumulated into BW bits; carry out of BW sets the sticky overflow flag; sat_en wraps -> clamps to 2^BW-1.
REQ-023 BIAS (1 cycle): result = acc + (bias_en ? c : 0) in BW+1 bits; carry ORs into flag; sat_en clamps; res_mat_o/of_mat_o registered at end of BIAS.
REQ-024 DONE (1 cycle): done_o=1; res_valid_o set, held until next accepted start or reset.
REQ-025 busy_o=1 in FEED, DRAIN, BIAS, DONE; start_i outside IDLE SHALL be ignored.
REQ-026 Latency without bubbles: start accepted cycle t -> done_o at t+K+2N+1 (N=4, K=4: t+13); each bubble adds 1.
REQ-027 K=0: result = bias or zero, flags 0, done_o at t+2.
REQ-028 k_len_i > K_MAX SHALL be clamped to K_MAX.

Reset
REQ-029 reset_i SHALL, at any state including mid-operation, force IDLE, clear skew pipes, valid tags, accumulators, counters.
REQ-030 Reset values: res_mat_o=0, of_mat_o=0, in_ready_o=0, busy_o=0, done_o=0, res_valid_o=0.

Structure
REQ-031 Shared package matmul_pkg SHALL hold the FSM state enum and width localparams (K_W, CNT_W, PROD_W).
REQ-032 Sub-module matmul_pe SHALL hold one PE: a/b/valid pass-through registers, multiply-accumulate, sticky overflow, saturation.

Verification
REQ-033 N=4, K=4, A=identity, B rows {1,2,3,4}x(r+1), bias off -> res=B, flags 0, done_o at t+13.
REQ-034 K=1, a_col={1,2,3,4}, b_row={5,6,7,8}, bias_en, C all 10 -> res(r,c)=(r+1)(c+5)+10.
REQ-035 K=4, in_valid_i low every other cycle -> result identical to REQ-033, done_o 4 cycles later.
REQ-036 BW=16, all operands 255, K=2, sat_en=1 -> all res 0xFFFF, all flags 1; sat_en=0 -> res 0xFC02, flags 1.
REQ-037 reset_i pulsed during DRAIN -> all outputs 0 next cycle; subsequent run correct.
REQ-038 start_i held high during busy, K=0 with C=7 -> second start ignored; res all 7, done_o at t+2.
